// File: rtl/sprite_line_renderer.sv
// Sprite compositor: renders line v+1 into a back line buffer while line v is shown from the front one.
// Optional macro SPRITE_TRANSPARENCY_EN makes TRANSP_KEY pixels see-through; default build draws opaque boxes.
module sprite_line_renderer #(
    parameter int               N_SPR      = 20,
    parameter int               SPR_W      = 32,
    parameter int               SPR_H      = 32,
    parameter int               H_ACTIVE   = 640,
    parameter int               V_ACTIVE   = 480,
    parameter int               V_TOTAL    = 525,
    parameter int               COLOR_W    = 24,
    parameter logic [COLOR_W-1:0] TRANSP_KEY = 24'hFF00FF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [9:0]                              VGA_HCOUNT,
    input  logic [9:0]                              VGA_VCOUNT,
    input  logic [N_SPR-1:0]                        spr_en,
    input  logic [N_SPR*10-1:0]                     spr_x,
    input  logic [N_SPR*10-1:0]                     spr_y,
    input  logic [COLOR_W-1:0]                      bg_color,
    output logic                                    rom_rd,
    output logic [((N_SPR > 1) ? $clog2(N_SPR) : 1)-1:0] rom_sel,
    output logic [$clog2(SPR_W*SPR_H)-1:0]          rom_addr,
    input  logic [COLOR_W-1:0]                      rom_data,
    output logic [7:0]                              VGA_R,
    output logic [7:0]                              VGA_G,
    output logic [7:0]                              VGA_B,
    output logic                                    busy,
    output logic                                    overrun
);

    localparam int SEL_W  = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int ADDR_W = $clog2(SPR_W*SPR_H);
    localparam int CNT_W  = $clog2(SPR_W+1);
    localparam int BUF_AW = $clog2(2*H_ACTIVE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DRAW = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP_ON = 1'b1;
`else
    localparam bit TRANSP_ON = 1'b0;
`endif

    logic [1:0]               state;
    logic [9:0]               vcount_q;
    logic [9:0]               target;
    logic                     buf_sel;
    logic [1:0][H_ACTIVE-1:0] valid;
    logic [N_SPR-1:0]         sh_en;
    logic [9:0]               sh_x [N_SPR];
    logic [9:0]               sh_y [N_SPR];
    logic [SEL_W-1:0]         spr_i;
    logic [CNT_W-1:0]         col_cnt;
    logic                     wr_pend;
    logic [10:0]              wr_px;
    logic [COLOR_W-1:0]       line_ram [2*H_ACTIVE];
    logic [COLOR_W-1:0]       pix_q;

    logic                     line_event;
    logic [9:0]               next_t;
    logic [9:0]               cur_x;
    logic [9:0]               cur_y;
    logic                     hit;
    logic [ADDR_W-1:0]        row_base;
    logic                     wr_ok;
    logic [BUF_AW-1:0]        wr_idx;
    logic                     front_sel;
    logic [BUF_AW-1:0]        rd_idx;
    logic                     disp_on;

    assign line_event = (VGA_VCOUNT != vcount_q);
    assign next_t     = (VGA_VCOUNT == 10'(V_TOTAL-1)) ? 10'd0 : VGA_VCOUNT + 10'd1;
    assign cur_x      = sh_x[spr_i];
    assign cur_y      = sh_y[spr_i];
    // 11-bit compare so a sprite near the bottom never wraps onto the top lines
    assign hit        = sh_en[spr_i] && ({1'b0, target} >= {1'b0, cur_y})
                        && ({1'b0, target} < ({1'b0, cur_y} + 11'(SPR_H)));
    assign row_base   = ADDR_W'(target - cur_y) * ADDR_W'(SPR_W);
    assign wr_ok      = wr_pend && !line_event && (wr_px < 11'(H_ACTIVE))
                        && !(TRANSP_ON && (rom_data == TRANSP_KEY));
    assign wr_idx     = buf_sel ? BUF_AW'(wr_px) : BUF_AW'(wr_px) + BUF_AW'(H_ACTIVE);
    // On the event clk the swap has not landed yet, so look through to the new front
    assign front_sel  = line_event ? ~buf_sel : buf_sel;
    assign rd_idx     = front_sel ? BUF_AW'(VGA_HCOUNT) + BUF_AW'(H_ACTIVE) : BUF_AW'(VGA_HCOUNT);
    assign disp_on    = (VGA_HCOUNT < 10'(H_ACTIVE)) && (VGA_VCOUNT < 10'(V_ACTIVE));

    assign busy  = (state != S_IDLE);
    assign VGA_R = pix_q[23:16];
    assign VGA_G = pix_q[15:8];
    assign VGA_B = pix_q[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            vcount_q <= '0;
            target   <= '0;
            buf_sel  <= 1'b0;
            valid    <= '0;
            sh_en    <= '0;
            for (int k = 0; k < N_SPR; k++) begin
                sh_x[k] <= '0;
                sh_y[k] <= '0;
            end
            spr_i    <= '0;
            col_cnt  <= '0;
            wr_pend  <= 1'b0;
            wr_px    <= '0;
            rom_rd   <= 1'b0;
            rom_sel  <= '0;
            rom_addr <= '0;
            overrun  <= 1'b0;
        end else begin
            vcount_q <= VGA_VCOUNT;
            wr_pend  <= rom_rd && !line_event;
            wr_px    <= {1'b0, cur_x} + 11'(col_cnt);
            if (wr_ok)
                valid[~buf_sel][wr_px[9:0]] <= 1'b1;
            if (line_event) begin
                // Any render still running is abandoned; its partial buffer goes on screen
                if (state != S_IDLE)
                    overrun <= 1'b1;
                buf_sel        <= ~buf_sel;
                valid[buf_sel] <= '0;
                sh_en          <= spr_en;
                for (int k = 0; k < N_SPR; k++) begin
                    sh_x[k] <= spr_x[k*10 +: 10];
                    sh_y[k] <= spr_y[k*10 +: 10];
                end
                target <= next_t;
                rom_rd <= 1'b0;
                spr_i  <= SEL_W'(N_SPR-1);
                state  <= (next_t < 10'(V_ACTIVE)) ? S_SCAN : S_IDLE;
            end else begin
                case (state)
                    S_SCAN: begin
                        if (hit) begin
                            state    <= S_DRAW;
                            rom_rd   <= 1'b1;
                            rom_sel  <= spr_i;
                            rom_addr <= row_base;
                            col_cnt  <= '0;
                        end else if (spr_i == '0) begin
                            state <= S_DONE;
                        end else begin
                            spr_i <= spr_i - SEL_W'(1);
                        end
                    end
                    S_DRAW: begin
                        if (col_cnt == CNT_W'(SPR_W)) begin
                            if (spr_i == '0) begin
                                state <= S_DONE;
                            end else begin
                                state <= S_SCAN;
                                spr_i <= spr_i - SEL_W'(1);
                            end
                        end else begin
                            col_cnt <= col_cnt + CNT_W'(1);
                            if (col_cnt == CNT_W'(SPR_W-1))
                                rom_rd <= 1'b0;
                            else
                                rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            line_ram[wr_idx] <= rom_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pix_q <= '0;
        else if (disp_on)
            pix_q <= valid[front_sel][VGA_HCOUNT] ? line_ram[rd_idx] : bg_color;
        else
            pix_q <= '0;
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: drives the VGA counters, models the sprite ROM and
// checks rendered pixels against hand-computed colours.
module tb_sprite_line_renderer;

    localparam int N_SPR = 20;

`ifdef SPRITE_TRANSPARENCY_EN
    localparam logic [23:0] EXP_KEY_OVER = 24'h555555;
    localparam logic [23:0] EXP_KEY_BG   = 24'h000080;
`else
    localparam logic [23:0] EXP_KEY_OVER = 24'hFF00FF;
    localparam logic [23:0] EXP_KEY_BG   = 24'hFF00FF;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         hcount;
    logic [9:0]         vcount;
    logic [N_SPR-1:0]   spr_en;
    logic [N_SPR*10-1:0] spr_x;
    logic [N_SPR*10-1:0] spr_y;
    logic [23:0]        bg_color;
    logic               rom_rd;
    logic [4:0]         rom_sel;
    logic [9:0]         rom_addr;
    logic [23:0]        rom_data;
    logic [7:0]         vga_r, vga_g, vga_b;
    logic               busy;
    logic               overrun;

    logic [23:0]        spr_color [N_SPR];
    logic               key_cols;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    sprite_line_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .VGA_HCOUNT (hcount),
        .VGA_VCOUNT (vcount),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .bg_color   (bg_color),
        .rom_rd     (rom_rd),
        .rom_sel    (rom_sel),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Sprite ROM: one solid colour per sprite, optionally keyed colour in sprite 0 columns 0..15
    always @(posedge clk) begin
        if (rom_rd)
            rom_data <= (key_cols && rom_sel == 5'd0 && rom_addr[4:0] < 5'd16) ?
                        24'hFF00FF : spr_color[rom_sel];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("render_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic setLine(input int v);
        @(negedge clk);
        vcount = 10'(v);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int v);
        setLine(v);
        waitIdle();
    endtask

    // Fresh events through line v-1 so the buffer shown on line v uses the current sprite setup
    task automatic showLine(input int v);
        int p = (v == 0) ? 524 : v - 1;
        applyStimulus(500);
        applyStimulus(p);
        applyStimulus(v);
    endtask

    task automatic checkPixel(input string tag, input int h, input logic [23:0] exp);
        @(negedge clk);
        hcount = 10'(h);
        @(negedge clk);
        checkOutput(tag, {8'd0, vga_r, vga_g, vga_b}, {8'd0, exp});
    endtask

    task automatic setSprite(input int k, input logic en, input int x, input int y, input logic [23:0] c);
        spr_en[k]        = en;
        spr_x[k*10 +: 10] = 10'(x);
        spr_y[k*10 +: 10] = 10'(y);
        spr_color[k]     = c;
    endtask

    task automatic clearSprites();
        for (int k = 0; k < N_SPR; k++)
            setSprite(k, 1'b0, 0, 0, 24'h0);
        key_cols = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        hcount   = '0;
        vcount   = '0;
        bg_color = 24'h000080;
        spr_en   = '0;
        spr_x    = '0;
        spr_y    = '0;
        clearSprites();
        repeat (3) @(negedge clk);
        checkOutput("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        checkOutput("rst_rom_rd", {31'd0, rom_rd}, 32'd0);
        checkOutput("rst_rom_sel", {27'd0, rom_sel}, 32'd0);
        checkOutput("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single opaque sprite and its vertical extent
        setSprite(0, 1'b1, 100, 50, 24'h112233);
        showLine(49);
        checkPixel("t1_l49_p100", 100, 24'h000080);
        showLine(50);
        checkPixel("t1_p99", 99, 24'h000080);
        checkPixel("t1_p100", 100, 24'h112233);
        checkPixel("t1_p131", 131, 24'h112233);
        checkPixel("t1_p131_hold", 131, 24'h112233);
        checkPixel("t1_p132", 132, 24'h000080);
        checkPixel("t1_hblank", 700, 24'h000000);
        showLine(81);
        checkPixel("t1_l81_p115", 115, 24'h112233);
        showLine(82);
        checkPixel("t1_l82_p100", 100, 24'h000080);
        checkPixel("t1_l82_p131", 131, 24'h000080);

        // Priority: sprite 0 drawn last wins the overlap
        setSprite(0, 1'b1, 100, 50, 24'hAAAAAA);
        setSprite(1, 1'b1, 110, 50, 24'h555555);
        showLine(50);
        checkPixel("t2_p105", 105, 24'hAAAAAA);
        checkPixel("t2_p110", 110, 24'hAAAAAA);
        checkPixel("t2_p131", 131, 24'hAAAAAA);
        checkPixel("t2_p132", 132, 24'h555555);
        checkPixel("t2_p141", 141, 24'h555555);
        checkPixel("t2_p142", 142, 24'h000080);

        // Transparency key in sprite 0 columns 0..15
        key_cols = 1'b1;
        showLine(50);
        checkPixel("t3_p100", 100, EXP_KEY_BG);
        checkPixel("t3_p110", 110, EXP_KEY_OVER);
        checkPixel("t3_p115", 115, EXP_KEY_OVER);
        checkPixel("t3_p116", 116, 24'hAAAAAA);
        clearSprites();

        // Horizontal clipping at the right edge, no wrap into column 0
        setSprite(0, 1'b1, 630, 50, 24'h112233);
        showLine(50);
        checkPixel("t4_p629", 629, 24'h000080);
        checkPixel("t4_p630", 630, 24'h112233);
        checkPixel("t4_p639", 639, 24'h112233);
        checkPixel("t4_p0", 0, 24'h000080);
        checkPixel("t4_p21", 21, 24'h000080);

        // Frame wrap and bottom edge
        setSprite(0, 1'b1, 100, 0, 24'h112233);
        showLine(0);
        checkPixel("t5_l0_p100", 100, 24'h112233);
        checkPixel("t5_l0_p132", 132, 24'h000080);
        setSprite(0, 1'b1, 100, 448, 24'h112233);
        showLine(447);
        checkPixel("t5_l447_p100", 100, 24'h000080);
        showLine(448);
        checkPixel("t5_l448_p100", 100, 24'h112233);
        showLine(479);
        checkPixel("t5_l479_p131", 131, 24'h112233);
        setLine(480);
        checkOutput("t5_skip_busy", {31'd0, busy}, 32'd0);
        checkPixel("t5_l480_p100", 100, 24'h000000);
        waitIdle();

        // Overrun: all sprites hit and the line changes far too early
        checkOutput("t6_overrun_clear", {31'd0, overrun}, 32'd0);
        for (int k = 0; k < N_SPR; k++)
            setSprite(k, 1'b1, k*30, 50, 24'h010101 * 24'(k+1));
        applyStimulus(500);
        applyStimulus(48);
        setLine(49);
        repeat (100) @(negedge clk);
        setLine(50);
        checkOutput("t6_overrun_set", {31'd0, overrun}, 32'd1);
        waitIdle();
        applyStimulus(51);
        checkOutput("t6_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Asynchronous reset in the middle of a DRAW
        hcount = 10'd200;
        setLine(52);
        begin
            int n = 0;
            while (rom_rd !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("t6_in_draw", {31'd0, rom_rd}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("t6_pre_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h070707);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_rom_rd", {31'd0, rom_rd}, 32'd0);
        checkOutput("t6_rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        checkOutput("t6_rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        waitIdle();

        // Clean operation after the reset
        clearSprites();
        setSprite(0, 1'b1, 100, 50, 24'h112233);
        showLine(50);
        checkPixel("t6_post_p100", 100, 24'h112233);
        checkPixel("t6_post_p570", 570, 24'h000080);
        checkOutput("t6_post_overrun", {31'd0, overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
